// File: rtl/fifo_sync_flags.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty thresholds and sticky error flags.
// Define FIFO_SYNC_FWFT_EN for first-word-fall-through read timing; standard registered read otherwise.
module fifo_sync_flags #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned FIFO_DEPTH    = 8,
  parameter int unsigned AFULL_THRESH  = FIFO_DEPTH - 2,
  parameter int unsigned AEMPTY_THRESH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cs,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  clr_err,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_valid,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DepthCnt  = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] AFullThr  = (AW+1)'(AFULL_THRESH);
  localparam logic [AW:0] AEmptyThr = (AW+1)'(AEMPTY_THRESH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [AW:0]           count_q, count_d;
  logic                  overflow_q, underflow_q;
  logic                  rd_acc, wr_acc;

  assign empty        = (count_q == '0);
  assign full         = (count_q == DepthCnt);
  assign almost_full  = (count_q >= AFullThr);
  assign almost_empty = (count_q <= AEmptyThr);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // A write into a full FIFO is legal only when a read frees a slot in the same cycle.
  assign rd_acc = cs & rd_en & ~empty;
  assign wr_acc = cs & wr_en & (~full | rd_acc);

  always_comb begin
    count_d = count_q;
    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr_q] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_acc) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      // Setting wins over clearing in the same cycle.
      overflow_q  <= (cs & wr_en & ~wr_acc) | (overflow_q & ~clr_err);
      underflow_q <= (cs & rd_en & empty) | (underflow_q & ~clr_err);
    end
  end

`ifdef FIFO_SYNC_FWFT_EN
  assign data_out = empty ? '0 : mem[rd_ptr_q];
  assign rd_valid = ~empty;
`else
  logic [DATA_WIDTH-1:0] data_out_q;
  logic                  rd_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_acc;
      if (rd_acc) data_out_q <= mem[rd_ptr_q];
    end
  end

  assign data_out = data_out_q;
  assign rd_valid = rd_valid_q;
`endif

endmodule

// File: tb/tb_fifo_sync_flags.sv
// Directed bench for fifo_sync_flags (standard read timing): a queue model of the FIFO
// contents feeds a scoreboard of expected read data compared when rd_valid pulses.
module tb_fifo_sync_flags;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cs, wr_en, rd_en, clr_err;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        rd_valid, empty, full, almost_full, almost_empty, overflow, underflow;
  logic [3:0]  count;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mq[$];     // model of FIFO contents
  logic [31:0] exp_q[$];  // scoreboard of expected read data
  logic        m_ov, m_uf;
  logic [31:0] m_dout;

  fifo_sync_flags dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cs           (cs),
    .wr_en        (wr_en),
    .rd_en        (rd_en),
    .data_in      (data_in),
    .clr_err      (clr_err),
    .data_out     (data_out),
    .rd_valid     (rd_valid),
    .empty        (empty),
    .full         (full),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    int n;
    n = mq.size();
    check({tag, " count"}, 32'(count), 32'(n));
    check({tag, " empty"}, 32'(empty), 32'(n == 0));
    check({tag, " full"}, 32'(full), 32'(n == 8));
    check({tag, " almost_full"}, 32'(almost_full), 32'(n >= 6));
    check({tag, " almost_empty"}, 32'(almost_empty), 32'(n <= 2));
    check({tag, " overflow"}, 32'(overflow), 32'(m_ov));
    check({tag, " underflow"}, 32'(underflow), 32'(m_uf));
  endtask

  task automatic step(input string tag, input logic c, input logic w, input logic r,
                      input logic [31:0] d, input logic clr);
    logic rd_ok, wr_ok;
    cs = c; wr_en = w; rd_en = r; data_in = d; clr_err = clr;
    rd_ok = c && r && (mq.size() > 0);
    wr_ok = c && w && ((mq.size() < 8) || rd_ok);
    m_ov  = (c && w && !wr_ok) ? 1'b1 : (clr ? 1'b0 : m_ov);
    m_uf  = (c && r && (mq.size() == 0)) ? 1'b1 : (clr ? 1'b0 : m_uf);
    if (rd_ok) exp_q.push_back(mq.pop_front());
    if (wr_ok) mq.push_back(d);
    @(posedge clk);
    #1;
    check({tag, " rd_valid"}, 32'(rd_valid), 32'(rd_ok));
    if (rd_ok) m_dout = exp_q.pop_front();
    check({tag, " data_out"}, data_out, m_dout);
    check_state(tag);
    cs = 1'b0; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
  endtask

  task automatic model_reset();
    mq.delete();
    exp_q.delete();
    m_ov = 1'b0; m_uf = 1'b0; m_dout = '0;
  endtask

  initial begin
    cs = 0; wr_en = 0; rd_en = 0; clr_err = 0; data_in = '0;
    rst_n = 1'b0;
    model_reset();
    #12;
    check("reset data_out", data_out, 32'h0);
    check("reset rd_valid", 32'(rd_valid), 32'h0);
    check_state("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Basic three-word write/read.
    step("w1", 1, 1, 0, 32'd1, 0);
    step("w10", 1, 1, 0, 32'd10, 0);
    step("w100", 1, 1, 0, 32'd100, 0);
    for (int i = 0; i < 3; i++) step("rd3", 1, 0, 1, '0, 0);

    // Fill to full, overflow on the ninth write, drain in order.
    for (int i = 0; i < 8; i++) step("fill", 1, 1, 0, 32'(1 << i), 0);
    check("full after fill", 32'(full), 32'h1);
    step("w9 reject", 1, 1, 0, 32'h999, 0);
    check("overflow after w9", 32'(overflow), 32'h1);
    for (int i = 0; i < 8; i++) step("drain", 1, 0, 1, '0, 0);
    check("empty after drain", 32'(empty), 32'h1);

    // Full with simultaneous read and write; 0xAA comes out last.
    for (int i = 0; i < 8; i++) step("refill", 1, 1, 0, 32'h10 + 32'(i), 0);
    step("full rw", 1, 1, 1, 32'hAA, 1);
    check("full rw count", 32'(count), 32'd8);
    check("full rw overflow", 32'(overflow), 32'h0);
    for (int i = 0; i < 8; i++) step("drain2", 1, 0, 1, '0, 0);

    // Empty with read and write: read rejected, word retained.
    step("empty rw", 1, 1, 1, 32'd5, 0);
    check("empty rw underflow", 32'(underflow), 32'h1);
    step("read 5", 1, 0, 1, '0, 0);

    // Errors: set overflow too, clear with cs low, then set-wins-over-clear.
    for (int i = 0; i < 9; i++) step("ovfill", 1, 1, 0, 32'h40 + 32'(i), 0);
    step("rd uf", 1, 0, 0, '0, 0);
    step("clr cs0", 0, 1, 1, 32'h55, 1);
    check("clr overflow", 32'(overflow), 32'h0);
    step("clr+reject", 1, 1, 0, 32'h66, 1);
    check("set wins overflow", 32'(overflow), 32'h1);
    step("cs0 hold", 0, 1, 1, 32'h67, 0);

    // Mid-stream reset with count=5.
    for (int i = 0; i < 3; i++) step("to5", 1, 0, 1, '0, 0);
    check("count 5", 32'(count), 32'd5);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("midrst data_out", data_out, 32'h0);
    check_state("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    step("post w", 1, 1, 0, 32'h77, 0);
    step("post r", 1, 0, 1, '0, 0);
    check("post r data", data_out, 32'h77);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
